// File: rtl/decode_pkg.sv
// Shared decode constants for the ID stage: opcodes, functs, ALU selects,
// PCSrc bit positions and the ID/EX register layout.
package decode_pkg;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    localparam int PCSRC_JR     = 0;
    localparam int PCSRC_JUMP   = 1;
    localparam int PCSRC_BRANCH = 2;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        alu_op_e     alu_op;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;
endpackage

// File: rtl/decode_regfile.sv
// 32-entry register file: two async read ports with write-through, one sync
// write port, $0 hard-wired to zero.
module decode_regfile import decode_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i
);
    logic [DATA_W-1:0] regs_q [32];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && wa_i != '0) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = (ra1_i == '0) ? '0 : (we_i && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
        rd2_o = (ra2_i == '0) ? '0 : (we_i && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
    end
endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, register read, branch/jump resolution with EX/MEM
// forwarding, hazard stall via a replay register, and the ID/EX register.
module decode_stage import decode_pkg::*; #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] instruction,
    input  logic [ADDR_W-1:0] pcPlusOne,
    input  logic              wbRegWrite,
    input  logic [4:0]        wbRd,
    input  logic [DATA_W-1:0] wbData,
    input  logic              exMemRegWrite,
    input  logic              exMemMemRead,
    input  logic [4:0]        exMemRd,
    input  logic [DATA_W-1:0] exMemAluResult,
    output logic [2:0]        PCSrc,
    output logic [ADDR_W-1:0] jumpAddr,
    output logic [ADDR_W-1:0] jrAddr,
    output logic [ADDR_W-1:0] branchAddr,
    output logic              pcWrite,
    output logic              IFFlush,
    output logic              idExRegWrite,
    output logic              idExMemRead,
    output logic              idExMemWrite,
    output logic              idExAluSrc,
    output logic [2:0]        idExAluOp,
    output logic [DATA_W-1:0] idExReadData1,
    output logic [DATA_W-1:0] idExReadData2,
    output logic [DATA_W-1:0] idExImm,
    output logic [4:0]        idExRs,
    output logic [4:0]        idExRt,
    output logic [4:0]        idExRd
);
    logic              rpl_vld_q, rpl_vld_d;
    logic [DATA_W-1:0] rpl_instr_q, rpl_instr_d;
    logic [ADDR_W-1:0] rpl_pc_q, rpl_pc_d;
    idex_t             idex_q, idex_d;

    logic [DATA_W-1:0] instr, rd1, rd2, rs_fwd, rt_fwd;
    logic [ADDR_W-1:0] pc1;
    logic [5:0]        op, fn;
    logic [4:0]        rs, rt, rd;
    logic r_alu, is_jr, is_j, is_lw, is_sw, is_beq, is_bne, vld_op;
    logic uses_rs, uses_rt, br_rs, br_rt, load_use, br_haz, stall, taken;

    function automatic logic hit(input logic [4:0] src, input logic [4:0] r);
        return (src != 5'd0) && (src == r);
    endfunction

    function automatic alu_op_e alu_of(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    assign instr = rpl_vld_q ? rpl_instr_q : instruction;
    assign pc1   = rpl_vld_q ? rpl_pc_q    : pcPlusOne;
    assign op    = instr[31:26];
    assign fn    = instr[5:0];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];

    assign r_alu  = (op == OP_RTYPE) && (fn == FN_ADD || fn == FN_SUB || fn == FN_AND ||
                                         fn == FN_OR  || fn == FN_SLT);
    assign is_jr  = (op == OP_RTYPE) && (fn == FN_JR);
    assign is_j   = (op == OP_J);
    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_beq = (op == OP_BEQ);
    assign is_bne = (op == OP_BNE);
    assign vld_op = r_alu | is_jr | is_j | is_lw | is_sw | is_beq | is_bne;

    assign uses_rs = r_alu | is_jr | is_lw | is_sw | is_beq | is_bne;
    assign uses_rt = r_alu | is_sw | is_beq | is_bne;
    assign br_rs   = is_jr | is_beq | is_bne;
    assign br_rt   = is_beq | is_bne;

    decode_regfile #(.DATA_W(DATA_W)) u_rf (
        .clock (clock),
        .reset (reset),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .we_i  (wbRegWrite),
        .wa_i  (wbRd),
        .wd_i  (wbData)
    );

    // Only ALU results in EX/MEM are forwardable; a load there must stall instead.
    assign rs_fwd = (exMemRegWrite && !exMemMemRead && hit(rs, exMemRd)) ? exMemAluResult : rd1;
    assign rt_fwd = (exMemRegWrite && !exMemMemRead && hit(rt, exMemRd)) ? exMemAluResult : rd2;

    assign load_use = idex_q.mem_read && idex_q.rt != 5'd0 &&
                      ((uses_rs && rs == idex_q.rt) || (uses_rt && rt == idex_q.rt));
    assign br_haz   = (br_rs && ((idex_q.reg_write && hit(rs, idex_q.rd)) ||
                                 (exMemMemRead && hit(rs, exMemRd)))) ||
                      (br_rt && ((idex_q.reg_write && hit(rt, idex_q.rd)) ||
                                 (exMemMemRead && hit(rt, exMemRd))));
    assign stall    = !reset && (load_use || br_haz);
    assign taken    = (is_beq && rs_fwd == rt_fwd) || (is_bne && rs_fwd != rt_fwd);

    assign jumpAddr   = instr[ADDR_W-1:0];
    assign jrAddr     = rs_fwd[ADDR_W-1:0];
    assign branchAddr = pc1 + instr[ADDR_W-1:0];

    always_comb begin
        PCSrc   = 3'b000;
        pcWrite = 1'b1;
        IFFlush = 1'b0;
        if (reset) begin
            pcWrite = 1'b0;
            IFFlush = 1'b1;
        end else if (stall) begin
            pcWrite = 1'b0;
        end else if (taken || is_j || is_jr) begin
            IFFlush = 1'b1;
            if (taken)     PCSrc[PCSRC_BRANCH] = 1'b1;
            else if (is_j) PCSrc[PCSRC_JUMP]   = 1'b1;
            else           PCSrc[PCSRC_JR]     = 1'b1;
        end
    end

    always_comb begin
        idex_d = '0;
        if (!reset && !stall && vld_op) begin
            idex_d.reg_write = r_alu | is_lw;
            idex_d.mem_read  = is_lw;
            idex_d.mem_write = is_sw;
            idex_d.alu_src   = is_lw | is_sw;
            idex_d.alu_op    = r_alu ? alu_of(fn) : (is_beq | is_bne) ? ALU_SUB : ALU_ADD;
            idex_d.rdata1    = rd1;
            idex_d.rdata2    = rd2;
            idex_d.imm       = {{16{instr[15]}}, instr[15:0]};
            idex_d.rs        = uses_rs ? rs : 5'd0;
            idex_d.rt        = (uses_rt | is_lw) ? rt : 5'd0;
            idex_d.rd        = r_alu ? rd : is_lw ? rt : 5'd0;
        end
    end

    // A stalled instruction (fresh or already replaying) is held for another try.
    assign rpl_vld_d   = stall;
    assign rpl_instr_d = stall ? instr : '0;
    assign rpl_pc_d    = stall ? pc1 : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q      <= '0;
            rpl_vld_q   <= 1'b0;
            rpl_instr_q <= '0;
            rpl_pc_q    <= '0;
        end else begin
            idex_q      <= idex_d;
            rpl_vld_q   <= rpl_vld_d;
            rpl_instr_q <= rpl_instr_d;
            rpl_pc_q    <= rpl_pc_d;
        end
    end

    assign idExRegWrite  = idex_q.reg_write;
    assign idExMemRead   = idex_q.mem_read;
    assign idExMemWrite  = idex_q.mem_write;
    assign idExAluSrc    = idex_q.alu_src;
    assign idExAluOp     = idex_q.alu_op;
    assign idExReadData1 = idex_q.rdata1;
    assign idExReadData2 = idex_q.rdata2;
    assign idExImm       = idex_q.imm;
    assign idExRs        = idex_q.rs;
    assign idExRt        = idex_q.rt;
    assign idExRd        = idex_q.rd;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, write-through, load-use replay,
// branch wrap, jr forwarding, jump vs. stall priority, reset mid-stall.
module tb_decode_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [6:0]  pcPlusOne;
    logic        wbRegWrite, exMemRegWrite, exMemMemRead;
    logic [4:0]  wbRd, exMemRd;
    logic [31:0] wbData, exMemAluResult;
    logic [2:0]  PCSrc, idExAluOp;
    logic [6:0]  jumpAddr, jrAddr, branchAddr;
    logic        pcWrite, IFFlush, idExRegWrite, idExMemRead, idExMemWrite, idExAluSrc;
    logic [31:0] idExReadData1, idExReadData2, idExImm;
    logic [4:0]  idExRs, idExRt, idExRd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset), .instruction(instruction), .pcPlusOne(pcPlusOne),
        .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
        .exMemRegWrite(exMemRegWrite), .exMemMemRead(exMemMemRead), .exMemRd(exMemRd),
        .exMemAluResult(exMemAluResult),
        .PCSrc(PCSrc), .jumpAddr(jumpAddr), .jrAddr(jrAddr), .branchAddr(branchAddr),
        .pcWrite(pcWrite), .IFFlush(IFFlush),
        .idExRegWrite(idExRegWrite), .idExMemRead(idExMemRead), .idExMemWrite(idExMemWrite),
        .idExAluSrc(idExAluSrc), .idExAluOp(idExAluOp),
        .idExReadData1(idExReadData1), .idExReadData2(idExReadData2), .idExImm(idExImm),
        .idExRs(idExRs), .idExRt(idExRt), .idExRd(idExRd)
    );

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, rs[4:0], rt[4:0], imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; instruction = '0; pcPlusOne = '0;
        wbRegWrite = 1'b0; wbRd = '0; wbData = '0;
        exMemRegWrite = 1'b0; exMemMemRead = 1'b0; exMemRd = '0; exMemAluResult = '0;

        // reset held two edges
        tick(); tick();
        chk("rst_pcWrite", {31'd0, pcWrite}, 32'd0);
        chk("rst_IFFlush", {31'd0, IFFlush}, 32'd1);
        chk("rst_PCSrc", {29'd0, PCSrc}, 32'd0);
        chk("rst_idExRegWrite", {31'd0, idExRegWrite}, 32'd0);
        chk("rst_idExRd", {27'd0, idExRd}, 32'd0);
        chk("rst_idExReadData1", idExReadData1, 32'd0);
        reset = 1'b0; #1;
        chk("rel_PCSrc", {29'd0, PCSrc}, 32'd0);
        chk("rel_pcWrite", {31'd0, pcWrite}, 32'd1);
        chk("rel_IFFlush", {31'd0, IFFlush}, 32'd0);
        tick();

        // write-through: WB $3=5 while decoding add $4,$3,$3
        wbRegWrite = 1'b1; wbRd = 5'd3; wbData = 32'h5;
        instruction = rtype(3, 3, 4, 6'h20); pcPlusOne = 7'd1;
        tick();
        wbRegWrite = 1'b0;
        chk("wt_rd1", idExReadData1, 32'h5);
        chk("wt_rd2", idExReadData2, 32'h5);
        chk("wt_rd", {27'd0, idExRd}, 32'd4);
        chk("wt_regwrite", {31'd0, idExRegWrite}, 32'd1);

        // add $6,$0,$3: $0 reads 0, $3 from the array
        instruction = rtype(0, 3, 6, 6'h20);
        tick();
        chk("zero_rd1", idExReadData1, 32'd0);
        chk("zero_rd2", idExReadData2, 32'h5);

        // lw $2,0($1) then add $5,$2,$2
        instruction = itype(6'h23, 1, 2, 16'h0); pcPlusOne = 7'd10;
        tick();
        chk("lw_memread", {31'd0, idExMemRead}, 32'd1);
        chk("lw_rt", {27'd0, idExRt}, 32'd2);
        chk("lw_alusrc", {31'd0, idExAluSrc}, 32'd1);
        instruction = rtype(2, 2, 5, 6'h20); pcPlusOne = 7'd11; #1;
        chk("lu_pcWrite", {31'd0, pcWrite}, 32'd0);
        chk("lu_PCSrc", {29'd0, PCSrc}, 32'd0);
        chk("lu_IFFlush", {31'd0, IFFlush}, 32'd0);
        tick();
        chk("lu_bubble_rw", {31'd0, idExRegWrite}, 32'd0);
        chk("lu_bubble_mr", {31'd0, idExMemRead}, 32'd0);
        instruction = rtype(1, 1, 8, 6'h25); pcPlusOne = 7'd12; #1;
        chk("rp_pcWrite", {31'd0, pcWrite}, 32'd1);
        tick();
        chk("rp_rs", {27'd0, idExRs}, 32'd2);
        chk("rp_rt", {27'd0, idExRt}, 32'd2);
        chk("rp_rd", {27'd0, idExRd}, 32'd5);
        tick();
        chk("after_rd", {27'd0, idExRd}, 32'd8);
        chk("after_aluop", {29'd0, idExAluOp}, 32'd3);

        // beq $1,$1,3 at pcPlusOne 126 wraps to 1; bne the same is untaken
        instruction = itype(6'h04, 1, 1, 16'd3); pcPlusOne = 7'd126; #1;
        chk("beq_PCSrc", {29'd0, PCSrc}, 32'b100);
        chk("beq_addr", {25'd0, branchAddr}, 32'd1);
        chk("beq_IFFlush", {31'd0, IFFlush}, 32'd1);
        instruction = itype(6'h05, 1, 1, 16'd3); #1;
        chk("bne_PCSrc", {29'd0, PCSrc}, 32'd0);
        chk("bne_IFFlush", {31'd0, IFFlush}, 32'd0);
        chk("bne_pcWrite", {31'd0, pcWrite}, 32'd1);
        tick();

        // add $7 then jr $7: stall once, then forward 0x40 from EX/MEM
        instruction = rtype(1, 1, 7, 6'h20); pcPlusOne = 7'd30;
        tick();
        instruction = rtype(7, 0, 0, 6'h08); pcPlusOne = 7'd31; #1;
        chk("jr_stall_pcWrite", {31'd0, pcWrite}, 32'd0);
        chk("jr_stall_PCSrc", {29'd0, PCSrc}, 32'd0);
        tick();
        exMemRegWrite = 1'b1; exMemRd = 5'd7; exMemAluResult = 32'h40;
        instruction = '0; #1;
        chk("jr_addr", {25'd0, jrAddr}, 32'd64);
        chk("jr_PCSrc", {29'd0, PCSrc}, 32'b001);
        chk("jr_IFFlush", {31'd0, IFFlush}, 32'd1);
        tick();
        exMemRegWrite = 1'b0; exMemRd = '0; exMemAluResult = '0;

        // j 0x15 arrives while a load-use stall is being replayed
        instruction = itype(6'h23, 1, 2, 16'h0); pcPlusOne = 7'd40;
        tick();
        instruction = rtype(2, 2, 5, 6'h20); pcPlusOne = 7'd41; #1;
        chk("js_stall_PCSrc", {29'd0, PCSrc}, 32'd0);
        tick();
        instruction = {6'h02, 26'h15}; pcPlusOne = 7'd42; #1;
        chk("js_replay_PCSrc", {29'd0, PCSrc}, 32'd0);
        tick();
        chk("j_addr", {25'd0, jumpAddr}, 32'd21);
        chk("j_PCSrc", {29'd0, PCSrc}, 32'b010);
        chk("j_IFFlush", {31'd0, IFFlush}, 32'd1);
        tick();

        // reset while a replay is pending discards it
        instruction = itype(6'h23, 1, 2, 16'h0); pcPlusOne = 7'd50;
        tick();
        instruction = rtype(2, 2, 5, 6'h20); pcPlusOne = 7'd51;
        tick();
        reset = 1'b1; instruction = rtype(1, 1, 8, 6'h25); pcPlusOne = 7'd52; #1;
        chk("mr_pcWrite", {31'd0, pcWrite}, 32'd0);
        chk("mr_IFFlush", {31'd0, IFFlush}, 32'd1);
        chk("mr_PCSrc", {29'd0, PCSrc}, 32'd0);
        tick();
        chk("mr_idExRegWrite", {31'd0, idExRegWrite}, 32'd0);
        chk("mr_idExRs", {27'd0, idExRs}, 32'd0);
        reset = 1'b0; #1;
        chk("mr_rel_pcWrite", {31'd0, pcWrite}, 32'd1);
        tick();
        chk("mr_no_replay_rd", {27'd0, idExRd}, 32'd8);

        // register file was cleared by reset
        instruction = rtype(3, 3, 4, 6'h20);
        tick();
        chk("rf_cleared", idExReadData1, 32'd0);

        // beq $2,$0 with a load of $2 in EX/MEM must stall, then resolve
        instruction = itype(6'h04, 2, 0, 16'd1); pcPlusOne = 7'd20;
        exMemMemRead = 1'b1; exMemRd = 5'd2; #1;
        chk("memld_stall", {31'd0, pcWrite}, 32'd0);
        tick();
        exMemMemRead = 1'b0; exMemRd = '0; instruction = '0; #1;
        chk("memld_PCSrc", {29'd0, PCSrc}, 32'b100);
        chk("memld_addr", {25'd0, branchAddr}, 32'd21);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
